adder_seq_ctrl: RTL and testbench
=================================

# adder_seq_ctrl

Multi-cycle controller that performs a W-bit add or subtract (W = N*M) by sequencing one shared N-bit ripple slice adder over M cycles. The carry between slices is chained through a register. It sits between a requester (CPU datapath or test harness) and the N-bit adder resource, trading latency for adder width. Operation uses a start/busy/done handshake; results are held until the next accepted request.

## Interface
- N, 4, slice width in bits (width of the shared adder), N >= 2
- M, 4, number of slices per operation, M >= 1; operand width W = N*M
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = x+y, 1 = x-y; captured with start
- x  input  W  operand A; captured with start
- y  input  W  operand B; captured with start
- busy  output  1  high while slices are being processed (RUN state)
- done  output  1  one-cycle pulse; result valid
- s  output  W  result, two's complement
- cout  output  1  carry out of bit W-1 (for sub: 1 = no borrow)
- overflow  output  1  signed overflow of the W-bit operation

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, start=1 at an edge:
  - latch x into xa.
  - latch y, or ~y when sub=1, into yb.
  - carry register c <= sub; slice index k <= 0; clear s, cout and overflow to 0.
  - go to RUN.
- IDLE, start=0: hold all outputs.
- RUN, each edge:
  - slice sum = xa[kN+N-1:kN] + yb[kN+N-1:kN] + c, computed as a ripple sum with carry-in.
  - write the sum into s[kN+N-1:kN]; c <= slice carry-out.
  - if k = M-1: set cout <= slice carry-out and overflow <= (a&b&~r)|(~a&~b&r), where a, b, r are the MSBs of the top xa slice, top yb slice and top sum slice; go to DONE.
  - otherwise k <= k+1.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Width rules:
  - all arithmetic is modulo 2^W; subtraction is x + ~y + 1.
  - the slice counter has width max(1, ceil(log2 M)); the counter wraps to 0 on return to IDLE.
- start is ignored in RUN and DONE; no queuing. A start held high through DONE is accepted in the following IDLE cycle.
- Changes on x, y or sub after acceptance do not affect the operation in progress.
- Asynchronous reset at any time, including mid-RUN: immediately IDLE, with k=0, c=0, busy=0, done=0, s=0, cout=0, overflow=0. The partial result is discarded.

## Timing
- Reset values: busy=0, done=0, s=0, cout=0, overflow=0.
- busy = (state==RUN); done = (state==DONE); both decoded from registered state, with no combinational path from inputs.
- Let T0 be the edge where start is accepted:
  - busy is high after T0 through edge T0+M.
  - slice k is written at edge T0+k+1.
  - done is high in the cycle after edge T0+M.
  - latency from accept to done = M+1 cycles.
- Minimum request spacing: M+2 cycles (accept, M RUN cycles, DONE, IDLE).
- s, cout and overflow are stable and valid from done rising until the next accepted start. s is partially updated during RUN and must not be consumed then.
- M=1 degenerates to a single RUN cycle: done 2 cycles after accept.

## Test plan
All scenarios use N=4, M=4, W=16.
- Add 0x1234 + 0x0FFF → s=0x2233, cout=0, overflow=0; done exactly 5 cycles after accept, with busy high for 4 cycles.
- Add 0x7FFF + 0x0001 → s=0x8000, overflow=1, cout=0. Add 0xFFFF + 0x0001 → s=0x0000, cout=1, overflow=0.
- Sub 0x0005 - 0x0007 → s=0xFFFE, cout=0, overflow=0. Sub 0x8000 - 0x0001 → s=0x7FFF, cout=1, overflow=1.
- Pulse start again during RUN with different operands → ignored: the first result is unchanged and only one done pulse appears. Start held high continuously → a new operation is accepted every 6 cycles.
- Assert rst in the 2nd RUN cycle → all outputs 0 immediately. After release, a new add 0x0001 + 0x0001 gives s=0x0002 with normal 5-cycle latency.
- Change x/y/sub every cycle during RUN after accepting 0xAAAA + 0x5555 → s=0xFFFF, cout=0, overflow=0.

Source files
------------

// File: rtl/adder_seq_ctrl_if.sv
// Request/result bundle for the sequenced slice adder.
// The requester drives start/sub/x/y; the controller returns
// busy/done and the held result with its carry and overflow flags.
interface adder_seq_ctrl_if #(
  parameter int N = 4,
  parameter int M = 4
);
  localparam int W = N * M;

  logic         start;
  logic         sub;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;
  logic         overflow;

  modport master (
    output start, sub, x, y,
    input  busy, done, s, cout, overflow
  );

  modport slave (
    input  start, sub, x, y,
    output busy, done, s, cout, overflow
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle W-bit add/subtract built from one shared N-bit ripple slice.
// Operands are captured on an accepted start; each RUN cycle adds one slice,
// least significant first, chaining the carry through c_reg. Subtraction is
// x + ~y + 1, with the +1 injected as the initial carry. The result, carry
// out and signed overflow stay held until the next accepted request.
module adder_seq_ctrl #(
  parameter int N = 4,
  parameter int M = 4
) (
  input logic             clk,
  input logic             rst,
  adder_seq_ctrl_if.slave bus
);
  localparam int W  = N * M;
  localparam int KW = (M > 1) ? $clog2(M) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(M - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [W-1:0]  xa_reg;
  logic [W-1:0]  yb_reg;
  logic [W-1:0]  s_reg;
  logic          c_reg;
  logic          cout_reg;
  logic          overflow_reg;
  logic [KW-1:0] k_reg;

  logic [N-1:0]  a_slice;
  logic [N-1:0]  b_slice;
  logic [N-1:0]  sum_slice;
  logic [N:0]    carry;
  logic          last_slice;

  // Operand slices currently being summed, selected by the slice index.
  assign a_slice    = xa_reg[k_reg*N +: N];
  assign b_slice    = yb_reg[k_reg*N +: N];
  assign last_slice = (k_reg == K_LAST);

  // Shared N-bit ripple adder: carry-in comes from the chained carry register.
  assign carry[0] = c_reg;
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ripple
      assign sum_slice[gi] = a_slice[gi] ^ b_slice[gi] ^ carry[gi];
      assign carry[gi+1]   = (a_slice[gi] & b_slice[gi]) |
                             (a_slice[gi] & carry[gi])   |
                             (b_slice[gi] & carry[gi]);
    end
  endgenerate

  // State register; reset returns to IDLE immediately, dropping any partial work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode: start only matters in IDLE, DONE always lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then write one result slice per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xa_reg       <= '0;
      yb_reg       <= '0;
      s_reg        <= '0;
      c_reg        <= 1'b0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      k_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            xa_reg       <= bus.x;
            yb_reg       <= bus.sub ? ~bus.y : bus.y;
            c_reg        <= bus.sub;
            k_reg        <= '0;
            s_reg        <= '0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
          end
        end
        RUN: begin
          s_reg[k_reg*N +: N] <= sum_slice;
          c_reg               <= carry[N];
          if (last_slice) begin
            // Top slice: its MSBs carry the operand and result sign bits.
            cout_reg     <= carry[N];
            overflow_reg <= (a_slice[N-1] & b_slice[N-1] & ~sum_slice[N-1]) |
                            (~a_slice[N-1] & ~b_slice[N-1] & sum_slice[N-1]);
            k_reg        <= '0;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status decoded purely from registered state.
  assign bus.busy     = (state_reg == RUN);
  assign bus.done     = (state_reg == DONE);
  assign bus.s        = s_reg;
  assign bus.cout     = cout_reg;
  assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl (N=4, M=4): directed operations with literal
// expectations, plus a cycle-by-cycle comparison against a full-width
// arithmetic model with an accept-to-done timeline.
module tb_adder_seq_ctrl;
  localparam int N = 4;
  localparam int M = 4;
  localparam int W = N * M;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  adder_seq_ctrl_if #(.N(N), .M(M)) bus_if ();

  adder_seq_ctrl #(.N(N), .M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected result from plain signed/unsigned integer arithmetic.
  function automatic logic [17:0] golden(input logic [15:0] a, input logic [15:0] b,
                                         input logic sb);
    int   ia;
    int   ib;
    int   r;
    logic c;
    logic v;
    ia = int'($signed(a));
    ib = int'($signed(b));
    r  = sb ? (ia - ib) : (ia + ib);
    v  = (r > 32767) || (r < -32768);
    c  = sb ? (a >= b) : ((int'(a) + int'(b)) > 65535);
    return {v, c, r[15:0]};
  endfunction

  // Model timeline: ph=0 idle, ph=1..M busy, ph=M+1 done.
  // mode: 0 outputs known zero, 1 result in flux, 2 result valid.
  int          ph   = 0;
  int          mode = 0;
  logic [15:0] es   = '0;
  logic        ec   = 1'b0;
  logic        eo   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph   <= 0;
      mode <= 0;
    end else if (ph == 0) begin
      if (bus_if.start) begin
        ph           <= 1;
        mode         <= 1;
        {eo, ec, es} <= golden(bus_if.x, bus_if.y, bus_if.sub);
      end
    end else if (ph == M + 1) begin
      ph <= 0;
    end else begin
      ph <= ph + 1;
      if (ph == M) mode <= 2;
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", int'(bus_if.busy), int'(ph >= 1 && ph <= M));
      chk("cyc_done", int'(bus_if.done), int'(ph == M + 1));
      if (mode == 0) begin
        chk("cyc_s_zero", int'(bus_if.s), 0);
        chk("cyc_cout_zero", int'(bus_if.cout), 0);
        chk("cyc_ovf_zero", int'(bus_if.overflow), 0);
      end else if (mode == 2) begin
        chk("cyc_s", int'(bus_if.s), int'(es));
        chk("cyc_cout", int'(bus_if.cout), int'(ec));
        chk("cyc_ovf", int'(bus_if.overflow), int'(eo));
      end
    end
  end

  // One operation; mode 1 pulses a competing start in RUN, mode 2 scrambles inputs.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sb,
                       input logic [15:0] xs, input logic xc, input logic xo,
                       input int opmode, input string nm);
    int cyc;
    int nbusy;
    int extra;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.x     = a;
    bus_if.y     = b;
    bus_if.sub   = sb;
    @(negedge clk);
    bus_if.start = 1'b0;
    cyc   = 1;
    nbusy = 0;
    while (!bus_if.done && cyc < 20) begin
      if (bus_if.busy) nbusy++;
      if (opmode == 2) begin
        bus_if.x   = 16'($urandom);
        bus_if.y   = 16'($urandom);
        bus_if.sub = 1'($urandom);
      end
      if (opmode == 1 && cyc == 2) begin
        bus_if.start = 1'b1;
        bus_if.x     = 16'hFFFF;
        bus_if.y     = 16'h0F0F;
        bus_if.sub   = 1'b1;
      end
      if (opmode == 1 && cyc == 3) bus_if.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    $display("op %s x=%h y=%h sub=%0d -> s=%h cout=%0d ovf=%0d latency=%0d busy=%0d",
             nm, a, b, sb, bus_if.s, bus_if.cout, bus_if.overflow, cyc, nbusy);
    chk({nm, "_latency"}, cyc, M + 1);
    chk({nm, "_busy_cycles"}, nbusy, M);
    chk({nm, "_s"}, int'(bus_if.s), int'(xs));
    chk({nm, "_cout"}, int'(bus_if.cout), int'(xc));
    chk({nm, "_ovf"}, int'(bus_if.overflow), int'(xo));
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.done) extra++;
    end
    chk({nm, "_extra_done"}, extra, 0);
    chk({nm, "_s_held"}, int'(bus_if.s), int'(xs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses[$];
    int cyc;
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.sub   = 1'b0;
    bus_if.x     = '0;
    bus_if.y     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus_if.busy), 0);
    chk("rst_done", int'(bus_if.done), 0);
    chk("rst_s", int'(bus_if.s), 0);
    chk("rst_cout", int'(bus_if.cout), 0);
    chk("rst_ovf", int'(bus_if.overflow), 0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Model pin: hand-computed values of the golden function.
    chk("model_pin_sub", int'(golden(16'h8000, 16'h0001, 1'b1)), int'({1'b1, 1'b1, 16'h7FFF}));
    chk("model_pin_add", int'(golden(16'hFFFF, 16'h0001, 1'b0)), int'({1'b0, 1'b1, 16'h0000}));

    do_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0, "add_basic");
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, "add_ovf");
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, "add_carry");
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, "sub_borrow");
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0, "sub_ovf");
    do_op(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 1, "start_in_run");
    do_op(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0, 2, "input_change");

    // Start held high: a new operation every M+2 cycles.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.x     = 16'h0100;
    bus_if.y     = 16'h0023;
    bus_if.sub   = 1'b0;
    for (cyc = 1; cyc <= 26; cyc++) begin
      @(negedge clk);
      if (bus_if.done) begin
        pulses.push_back(cyc);
        chk("held_s", int'(bus_if.s), 16'h0123);
      end
    end
    bus_if.start = 1'b0;
    $display("op held_start pulses=%0d", pulses.size());
    chk("held_pulse_count", pulses.size(), 4);
    for (int i = 1; i < pulses.size(); i++) begin
      chk("held_spacing", pulses[i] - pulses[i-1], M + 2);
    end
    repeat (8) @(negedge clk);

    // Reset asserted in the 2nd RUN cycle.
    bus_if.start = 1'b1;
    bus_if.x     = 16'h1234;
    bus_if.y     = 16'h0001;
    bus_if.sub   = 1'b0;
    @(negedge clk);
    bus_if.start = 1'b0;
    chk("pre_rst_busy", int'(bus_if.busy), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    $display("op mid_run_reset busy=%0d done=%0d s=%h", bus_if.busy, bus_if.done, bus_if.s);
    chk("mrst_busy", int'(bus_if.busy), 0);
    chk("mrst_done", int'(bus_if.done), 0);
    chk("mrst_s", int'(bus_if.s), 0);
    chk("mrst_cout", int'(bus_if.cout), 0);
    chk("mrst_ovf", int'(bus_if.overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, "after_reset");

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
